reg_display_scanner: RTL and testbench
======================================

# reg_display_scanner

Debug read-out engine that consumes the register file's display port, which is a `rdisp` select in and a `ddisp` data out. It holds a selected register index and drives it onto `rdisp`. It snapshots `ddisp` and serializes the value as a 12-character ASCII frame over a valid/ready character stream, which feeds the board's LCD/UART character sink. The user steps the index with button pulses, or the block auto-scans; frames repeat continuously so that live register changes stay visible.

## Interface
- `SCAN_DIV`, default 50_000_000: clock cycles between auto-advance requests; legal range is ≥ 2.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `btn_next`  in  1  single-cycle debounced pulse; requests index + 1.
- `btn_prev`  in  1  single-cycle debounced pulse; requests index − 1.
- `auto_en`  in  1  level; enables auto-advance.
- `rdisp`  out  5  selected register index, registered; feeds the register file display select.
- `ddisp`  in  32  register value returned for `rdisp`.
- `char_data`  out  8  ASCII character.
- `char_valid`  out  1  `char_data` is valid.
- `char_ready`  in  1  sink accepts the character.
- `frame_start`  out  1  high while the current valid character is character 0 of a frame.

## Operation
- Frame format, 12 chars, in order:
  - `'R'`
  - tens digit of index, `'0'`..`'3'`
  - ones digit, `'0'`..`'9'`
  - `':'`
  - 8 hex digits of the snapshot, MSB nibble first, uppercase `'0'-'9'`, `'A'-'F'`.
- FSM states: IDLE → SETTLE → CAPTURE → EMIT → IDLE.
  - IDLE: apply the pending index update, if any, to the index register, which is `rdisp`; go to SETTLE.
  - SETTLE: one cycle for `ddisp` to follow the new `rdisp`.
  - CAPTURE: snapshot ← `ddisp`; char counter ← 0; go to EMIT.
  - EMIT: `char_valid` = 1. On `char_valid && char_ready` the counter increments. A handshake on char 11 goes to IDLE.
- Pending update is a 2-bit request latch: none / inc / dec.
  - It is set by `btn_next` (inc), by `btn_prev` (dec), or by the auto tick (inc, only when `auto_en`=1).
  - A later request overwrites an earlier one.
  - `btn_next` and `btn_prev` in the same cycle cancel: the latch is unchanged.
  - A button in the same cycle as the auto tick: the button wins.
  - The latch is consumed and cleared in IDLE. Requests arriving during a frame never alter the frame in progress.
- Index arithmetic: 5-bit modulo; 31 + 1 → 0, 0 − 1 → 31.
- Auto tick counter:
  - Counts 0..`SCAN_DIV`−1 while `auto_en`=1 and pulses a tick on wrap.
  - Held at 0 while `auto_en`=0.
- Backpressure:
  - `char_data` and `frame_start` stay stable while `char_valid && !char_ready`.
  - `char_valid` never drops before its handshake.
- Snapshot is frozen for the whole frame; register writes mid-frame appear in the next frame.

## Timing
- Reset values:
  - `rdisp` = 0, index = 0, pending = none, tick counter = 0.
  - `char_valid` = 0, `char_data` = 0, `frame_start` = 0, state = IDLE.
- Reset mid-frame aborts immediately. No further characters are emitted, and the frame restarts from IDLE after release.
- After reset release: IDLE at edge 1, SETTLE at edge 2, CAPTURE at edge 3, `char_valid`=1 with `'R'` and `frame_start`=1 after edge 4.
- With `char_ready` tied high, one character transfers per cycle. Frame period is 15 cycles (12 EMIT + IDLE + SETTLE + CAPTURE).
- An index change is visible on `rdisp` one cycle after the IDLE that consumes it.
- Maximum latency from a button pulse to the new index's `'R'` is one full frame plus 3 cycles.

## Structure
- Shared package `reg_display_pkg` contains:
  - the state enum: IDLE, SETTLE, CAPTURE, EMIT;
  - the pending-request enum;
  - character constants `CH_R`, `CH_COLON`, `CH_0`, `CH_A`;
  - the constant `FRAME_LEN` = 12.
- One sub-module, `nibble_to_ascii`: combinational 4-bit to 8-bit uppercase hex digit. It is reused for the hex nibbles; decimal digits use the same mapping for 0-9.
- Tens/ones digits come from a compare-subtract on the 5-bit index; no divider.

## Test plan
- Reset release, register 0 (reads 0), `char_ready`=1 → exact stream `"R00:00000000"`, `frame_start` only on `'R'`, first `char_valid` after edge 4, frame repeats every 15 cycles.
- Register 5 = `0xDEADBEEF`, `btn_next` pulsed 5 times with frames completing between pulses → stream settles on `"R05:DEADBEEF"`.
- Index 0, `btn_prev` → `rdisp`=31, `"R31:..."`. Then `btn_next` → `rdisp`=0. Then `btn_next` and `btn_prev` in the same cycle → index stays 0.
- Random `char_ready` stalls of 0-5 cycles mid-frame → `char_data` held stable during stalls; 12 characters delivered, none lost or duplicated. Register 5 rewritten to `0x12345678` mid-frame → current frame still shows `DEADBEEF`, next frame shows `12345678`.
- `SCAN_DIV`=20, `auto_en`=1, `char_ready`=1 → index advances 0, 1, 2, … at frame boundaries after each tick; index wraps 31 → 0.
- Reset asserted during EMIT on char 6 → `char_valid`=0 at once, all outputs at reset values; after release the stream restarts with `"R00:"`.

Source files
------------

// File: rtl/reg_display_scanner_pkg.sv
// Shared types and constants for the register display scanner.
package reg_display_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    EMIT    = 2'd3
  } state_t;

  // Pending index request latch
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_INC  = 2'd1,
    PEND_DEC  = 2'd2
  } pend_t;

  // ASCII characters used in the frame
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_A     = 8'h41;

  // Characters per frame and derived widths
  localparam int FRAME_LEN = 12;
  localparam int IDX_W     = 5;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/reg_display_scanner_nibble.sv
// Combinational 4-bit to uppercase ASCII hex digit. Values 0-9 double as
// decimal digits.
module nibble_to_ascii
  import reg_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_char
);

  // Map 0-9 onto '0'-'9' and 10-15 onto 'A'-'F'
  always_comb begin
    o_char = CH_0 + {4'b0000, i_nibble};
    if (i_nibble >= 4'd10) begin
      o_char = CH_A + {4'b0000, i_nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/reg_display_scanner.sv
// Debug read-out engine: selects a register via rdisp, snapshots ddisp and
// streams "Rnn:HHHHHHHH" frames over a valid/ready character interface.
module reg_display_scanner
  import reg_display_pkg::*;
#(
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             auto_en,
  output logic [IDX_W-1:0] rdisp,
  input  logic [31:0]      ddisp,
  output logic [7:0]       char_data,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             frame_start
);

  localparam int TICK_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  LAST_CHAR = CNT_W'(FRAME_LEN - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_armed;
  logic [IDX_W-1:0]   r_index;
  pend_t              r_pending;
  pend_t              w_pending_next;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic               w_tick;
  logic [31:0]        r_snapshot;
  logic [CNT_W-1:0]   r_char_cnt;
  logic               w_emit;
  logic               w_handshake;
  logic               w_consume;
  logic [3:0]         w_tens;
  logic [3:0]         w_ones;
  logic [7:0]         w_tens_char;
  logic [7:0]         w_ones_char;
  logic [7:0]         w_hex_char [8];
  logic [2:0]         w_hex_sel;
  logic [7:0]         w_char;

  assign w_emit      = (r_state == EMIT);
  assign w_handshake = w_emit && char_ready;
  // The first edge after reset release is spent in IDLE without advancing,
  // so the first frame appears after edge 4.
  assign w_consume   = (r_state == IDLE) && r_armed;
  assign w_tick      = auto_en && (r_tick_cnt == TICK_MAX);

  // State register and arming flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_armed <= 1'b1;
    end
  end

  // Next-state logic: one cycle each in IDLE/SETTLE/CAPTURE, then 12 chars
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_armed) w_state_next = SETTLE;
      SETTLE:  w_state_next = CAPTURE;
      CAPTURE: w_state_next = EMIT;
      EMIT:    if (w_handshake && (r_char_cnt == LAST_CHAR)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request latch: buttons beat the auto tick, both buttons together cancel,
  // and the value is cleared when IDLE consumes it
  always_comb begin
    w_pending_next = w_consume ? PEND_NONE : r_pending;
    if (btn_next && !btn_prev) begin
      w_pending_next = PEND_INC;
    end else if (btn_prev && !btn_next) begin
      w_pending_next = PEND_DEC;
    end else if (!btn_next && !btn_prev && w_tick) begin
      w_pending_next = PEND_INC;
    end
  end

  // Pending request register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= PEND_NONE;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // Index register: modulo-32 step applied only in IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_index <= '0;
    end else if (w_consume) begin
      case (r_pending)
        PEND_INC: r_index <= r_index + 5'd1;
        PEND_DEC: r_index <= r_index - 5'd1;
        default:  r_index <= r_index;
      endcase
    end
  end

  // Auto-advance divider, held at zero while disabled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (!auto_en || (r_tick_cnt == TICK_MAX)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Snapshot capture and character counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_snapshot <= '0;
      r_char_cnt <= '0;
    end else if (r_state == CAPTURE) begin
      r_snapshot <= ddisp;
      r_char_cnt <= '0;
    end else if (w_handshake) begin
      r_char_cnt <= r_char_cnt + 1'b1;
    end
  end

  // Decimal split of the index by compare-subtract
  always_comb begin
    w_tens = 4'd0;
    w_ones = r_index[3:0];
    if (r_index >= 5'd30) begin
      w_tens = 4'd3;
      w_ones = 4'(r_index - 5'd30);
    end else if (r_index >= 5'd20) begin
      w_tens = 4'd2;
      w_ones = 4'(r_index - 5'd20);
    end else if (r_index >= 5'd10) begin
      w_tens = 4'd1;
      w_ones = 4'(r_index - 5'd10);
    end
  end

  nibble_to_ascii u_tens (
    .i_nibble (w_tens),
    .o_char   (w_tens_char)
  );

  nibble_to_ascii u_ones (
    .i_nibble (w_ones),
    .o_char   (w_ones_char)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_hex
      nibble_to_ascii u_hex (
        .i_nibble (r_snapshot[4*gi +: 4]),
        .o_char   (w_hex_char[gi])
      );
    end
  endgenerate

  // Chars 4..11 carry nibbles 7..0 (MSB first)
  assign w_hex_sel = 3'(4'd11 - r_char_cnt);

  // Character select; zero outside EMIT
  always_comb begin
    w_char = 8'h00;
    if (w_emit) begin
      case (r_char_cnt)
        4'd0:    w_char = CH_R;
        4'd1:    w_char = w_tens_char;
        4'd2:    w_char = w_ones_char;
        4'd3:    w_char = CH_COLON;
        default: w_char = w_hex_char[w_hex_sel];
      endcase
    end
  end

  assign rdisp       = r_index;
  assign char_data   = w_char;
  assign char_valid  = w_emit;
  assign frame_start = w_emit && (r_char_cnt == '0);

endmodule

// File: tb/tb_reg_display_scanner.sv
// Randomized self-checking bench for reg_display_scanner with a string-level
// frame model and a behavioural register file.
module tb_reg_display_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_next = 1'b0;
  logic        btn_prev = 1'b0;
  logic        auto_en = 1'b0;
  logic [4:0]  rdisp;
  logic [31:0] ddisp;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready = 1'b1;
  logic        frame_start;

  logic [31:0] regs [32];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          nfr = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign ddisp = regs[rdisp];

  reg_display_scanner #(.SCAN_DIV(20)) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .auto_en     (auto_en),
    .rdisp       (rdisp),
    .ddisp       (ddisp),
    .char_data   (char_data),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame text built directly from the frame format
  function automatic string frame_of(input int idx, input logic [31:0] v);
    string hexd;
    string s;
    hexd = "0123456789ABCDEF";
    s = $sformatf("R%0d%0d:", idx / 10, idx % 10);
    for (int i = 7; i >= 0; i--) s = $sformatf("%s%c", s, hexd[(v >> (4 * i)) & 32'hF]);
    return s;
  endfunction

  task automatic check_frame(input string tag, input string s, input string exp);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("%s[%0d]", tag, i), (i < s.len()) ? 32'(s[i]) : 32'h0, 32'(exp[i]));
    end
  endtask

  // Collect the next complete frame; optional random stalls and a register
  // write once wr_at characters have been accepted
  task automatic collect_frame(input bit stall, input int wr_at, input int wr_idx,
                               input logic [31:0] wr_val, output string s, output int t0);
    int   got = 0;
    int   budget = 0;
    int   stall_left = 0;
    bit   started = 0;
    bit   was_stall = 0;
    bit   wrote = 0;
    logic [7:0] held = 8'h00;
    s = "";
    t0 = 0;
    while (got < 12 && budget < 400) begin
      @(posedge clock); #1;
      budget++;
      if (stall && stall_left > 0) begin
        char_ready = 1'b0;
        stall_left--;
      end else begin
        char_ready = 1'b1;
        if (stall && $urandom_range(0, 2) == 0) stall_left = $urandom_range(0, 5);
      end
      @(negedge clock);
      if (was_stall) begin
        chk("stall_valid", 32'(char_valid), 32'd1);
        chk("stall_hold", 32'(char_data), 32'(held));
        was_stall = 0;
      end
      if (!started && char_valid && frame_start) begin
        started = 1;
        t0 = cyc;
      end
      if (started && char_valid) begin
        chk("frame_start", 32'(frame_start), (got == 0) ? 32'd1 : 32'd0);
        if (char_ready) begin
          s = $sformatf("%s%c", s, char_data);
          got++;
          if (!wrote && wr_at >= 0 && got == wr_at) begin
            regs[wr_idx] = wr_val;
            wrote = 1;
          end
        end else begin
          held = char_data;
          was_stall = 1;
        end
      end
    end
    char_ready = 1'b1;
    if (got < 12) chk("frame_timeout", 32'(got), 32'd12);
    nfr++;
    $display("frame %0d @%0d: %s", nfr, t0, s);
  endtask

  task automatic pulse(input bit nxt, input bit prv);
    @(posedge clock); #1;
    btn_next = nxt;
    btn_prev = prv;
    @(posedge clock); #1;
    btn_next = 1'b0;
    btn_prev = 1'b0;
  endtask

  // Expect the reset values, then the first 'R' exactly after edge 4
  task automatic check_release(input string tag);
    chk({tag, "_rst_valid"}, 32'(char_valid), 32'd0);
    chk({tag, "_rst_data"}, 32'(char_data), 32'd0);
    chk({tag, "_rst_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_rst_rdisp"}, 32'(rdisp), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clock); #1;
      chk($sformatf("%s_valid_e%0d", tag, e), 32'(char_valid), (e == 4) ? 32'd1 : 32'd0);
    end
    chk({tag, "_first_char"}, 32'(char_data), 32'h52);
    chk({tag, "_first_fs"}, 32'(frame_start), 32'd1);
    chk({tag, "_first_rdisp"}, 32'(rdisp), 32'd0);
  endtask

  // Step the index with a button pulse and confirm the settled frame
  task automatic step_and_check(input string tag, input bit nxt, input bit prv, input int exp_idx);
    string s;
    int    t;
    pulse(nxt, prv);
    collect_frame(0, -1, 0, 32'h0, s, t);
    collect_frame(0, -1, 0, 32'h0, s, t);
    check_frame(tag, s, frame_of(exp_idx, regs[exp_idx]));
    chk({tag, "_rdisp"}, 32'(rdisp), 32'(exp_idx));
  endtask

  initial begin
    string s;
    string s2;
    int    t0;
    int    t1;
    int    idx;
    bit    wrapped;
    bit    ok;
    int    budget;

    regs[0] = 32'h0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    regs[5] = 32'hDEADBEEF;

    // Reset state and release timing
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_release("boot");
    collect_frame(0, -1, 0, 32'h0, s, t0);
    check_frame("r0_frame", s, frame_of(0, 32'h0));
    collect_frame(0, -1, 0, 32'h0, s2, t1);
    check_frame("r0_frame2", s2, "R00:00000000");
    chk("frame_period", 32'(t1 - t0), 32'd15);

    // Wrap down, wrap up, simultaneous buttons cancel
    step_and_check("prev_wrap", 0, 1, 31);
    step_and_check("next_wrap", 1, 0, 0);
    step_and_check("both_cancel", 1, 1, 0);

    // Step up to register 5 one pulse at a time
    for (int k = 1; k <= 5; k++) step_and_check($sformatf("next%0d", k), 1, 0, k);

    // Backpressure with a mid-frame register rewrite
    collect_frame(1, 6, 5, 32'h12345678, s, t0);
    check_frame("stall_old", s, frame_of(5, 32'hDEADBEEF));
    collect_frame(1, -1, 0, 32'h0, s, t0);
    check_frame("stall_new", s, frame_of(5, 32'h12345678));

    // Auto-scan: each frame shows the same index or the next one, until wrap
    @(posedge clock); #1;
    auto_en = 1'b1;
    idx = 5;
    wrapped = 0;
    budget = 0;
    while (!wrapped && budget < 60) begin
      budget++;
      collect_frame(0, -1, 0, 32'h0, s, t0);
      ok = 0;
      if (s == frame_of(idx, regs[idx])) begin
        ok = 1;
      end else if (s == frame_of((idx + 1) % 32, regs[(idx + 1) % 32])) begin
        ok = 1;
        if (idx == 31) wrapped = 1;
        idx = (idx + 1) % 32;
      end
      chk($sformatf("auto_frame%0d", budget), 32'(ok), 32'd1);
    end
    chk("auto_wrapped", 32'(wrapped), 32'd1);
    @(posedge clock); #1;
    auto_en = 1'b0;

    // Reset during EMIT on character 6
    budget = 0;
    do begin
      @(negedge clock);
      budget++;
    end while (!(char_valid && frame_start) && budget < 100);
    chk("mid_found_frame", 32'(char_valid && frame_start), 32'd1);
    repeat (6) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_release("midrst");
    collect_frame(0, -1, 0, 32'h0, s, t0);
    check_frame("after_rst", s, frame_of(0, regs[0]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
